// File: rtl/toy_pack.sv
// Shared icache types and widths for the tag/data-array slice.
// Refill beat, data-array read request and read response payloads.
`timescale 1ns/1ps
package toy_pack;

  localparam int unsigned ICACHE_INDEX_WIDTH      = 4;
  localparam int unsigned ICACHE_WAY_NUM          = 2;
  localparam int unsigned ICACHE_WAY_WIDTH        = 1;
  localparam int unsigned ICACHE_TXNID_WIDTH      = 8;
  localparam int unsigned MSHR_ENTRY_INDEX_WIDTH  = 2;
  localparam int unsigned LINEFILL_BEAT_NUM       = 4;
  localparam int unsigned ICACHE_BEAT_WIDTH       = 32;
  localparam int unsigned ICACHE_LINE_WIDTH       = LINEFILL_BEAT_NUM * ICACHE_BEAT_WIDTH;
  localparam int unsigned LINEFILL_BEAT_CNT_WIDTH = $clog2(LINEFILL_BEAT_NUM);

  typedef struct packed {
    logic [ICACHE_INDEX_WIDTH-1:0] dataram_rd_index;
    logic [ICACHE_WAY_WIDTH-1:0]   dataram_rd_way;
    logic [ICACHE_TXNID_WIDTH-1:0] dataram_rd_txnid;
  } dataram_rd_pld_t;

  typedef struct packed {
    logic [ICACHE_INDEX_WIDTH-1:0]     index;
    logic [ICACHE_WAY_WIDTH-1:0]       way;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_index;
    logic [ICACHE_BEAT_WIDTH-1:0]      beat_data;
  } linefill_beat_t;

  typedef struct packed {
    logic [ICACHE_TXNID_WIDTH-1:0] txnid;
    logic [ICACHE_LINE_WIDTH-1:0]  data;
  } dataram_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite
  } refill_state_e;

endpackage

// File: rtl/icache_data_resp_fifo.sv
// Two-entry valid/ready response FIFO; the producer guarantees it never pushes when full.
`timescale 1ns/1ps
module icache_data_resp_fifo
  import toy_pack::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  dataram_resp_t push_data,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output dataram_resp_t pop_data,
  output logic [1:0]    cnt
);

  dataram_resp_t mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  assign pop_vld  = (cnt_q != 2'd0);
  assign pop      = pop_vld && pop_rdy;
  assign pop_data = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/toy_mem_model_bit.sv
// Single-port RAM model with a registered (1-cycle) read; contents are never reset.
`timescale 1ns/1ps
module toy_mem_model_bit #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) begin
        mem_q[addr] <= wr_data;
      end else begin
        rd_data_q <= mem_q[addr];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/icache_data_array_ctrl.sv
// Icache data array: assembles refill beats into lines, writes them per way,
// and serves tag-hit reads through a registered RAM read and a 2-entry response FIFO.
`timescale 1ns/1ps
module icache_data_array_ctrl
  import toy_pack::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              dataram_rd_vld,
  output logic                              dataram_rd_rdy,
  input  dataram_rd_pld_t                   dataram_rd_pld,
  input  logic                              linefill_vld,
  output logic                              linefill_rdy,
  input  linefill_beat_t                    linefill_pld,
  output logic                              linefill_done,
  output logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_done_index,
  output logic                              resp_vld,
  input  logic                              resp_rdy,
  output dataram_resp_t                     resp_pld
);

  refill_state_e                      state_q, state_d;
  logic [LINEFILL_BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [ICACHE_LINE_WIDTH-1:0]       line_q, line_d;
  logic [ICACHE_INDEX_WIDTH-1:0]      idx_q, idx_d;
  logic [ICACHE_WAY_WIDTH-1:0]        way_q, way_d;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  entry_q, entry_d;
  logic                               done_q, done_d;

  logic                               pipe_vld_q, pipe_vld_d;
  logic [ICACHE_TXNID_WIDTH-1:0]      pipe_txnid_q, pipe_txnid_d;
  logic [ICACHE_WAY_WIDTH-1:0]        pipe_way_q, pipe_way_d;

  logic                               beat_acc, last_beat, ram_wr, rd_acc, resp_pop;
  logic [1:0]                         fifo_cnt;
  logic [2:0]                         occupancy;
  logic [ICACHE_INDEX_WIDTH-1:0]      ram_addr;
  logic [ICACHE_LINE_WIDTH-1:0]       way_rd_data [ICACHE_WAY_NUM];
  dataram_resp_t                      push_data;

  assign linefill_rdy = (state_q != StWrite);
  assign beat_acc     = linefill_vld && linefill_rdy;
  assign last_beat    = (beat_cnt_q == LINEFILL_BEAT_CNT_WIDTH'(LINEFILL_BEAT_NUM - 1));
  assign ram_wr       = (state_q == StWrite);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    line_d     = line_q;
    idx_d      = idx_q;
    way_d      = way_q;
    entry_d    = entry_q;
    done_d     = ram_wr;
    if (beat_acc) begin
      line_d[int'(beat_cnt_q)*ICACHE_BEAT_WIDTH +: ICACHE_BEAT_WIDTH] = linefill_pld.beat_data;
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
      // Line address and MSHR entry come from beat 0 only.
      if (state_q == StIdle) begin
        idx_d   = linefill_pld.index;
        way_d   = linefill_pld.way;
        entry_d = linefill_pld.entry_index;
      end
    end
    unique case (state_q)
      StIdle:    if (beat_acc) state_d = last_beat ? StWrite : StCollect;
      StCollect: if (beat_acc && last_beat) state_d = StWrite;
      StWrite:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Read credit: entries already queued plus the one in flight must leave room for a new one.
  assign resp_pop       = resp_vld && resp_rdy;
  assign occupancy      = {1'b0, fifo_cnt} + {2'b00, pipe_vld_q} - {2'b00, resp_pop};
  assign dataram_rd_rdy = !ram_wr && (occupancy < 3'd2);
  assign rd_acc         = dataram_rd_vld && dataram_rd_rdy;

  always_comb begin
    pipe_vld_d   = rd_acc;
    pipe_txnid_d = pipe_txnid_q;
    pipe_way_d   = pipe_way_q;
    if (rd_acc) begin
      pipe_txnid_d = dataram_rd_pld.dataram_rd_txnid;
      pipe_way_d   = dataram_rd_pld.dataram_rd_way;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      idx_q      <= '0;
      way_q      <= '0;
      entry_q    <= '0;
      done_q     <= 1'b0;
      pipe_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
      entry_q    <= entry_d;
      done_q     <= done_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q       <= line_d;
    pipe_txnid_q <= pipe_txnid_d;
    pipe_way_q   <= pipe_way_d;
  end

  assign linefill_done       = done_q;
  assign linefill_done_index = entry_q;
  assign ram_addr            = ram_wr ? idx_q : dataram_rd_pld.dataram_rd_index;

  for (genvar w = 0; w < ICACHE_WAY_NUM; w++) begin : g_way
    logic ram_en;
    assign ram_en = (ram_wr && (way_q == ICACHE_WAY_WIDTH'(w))) ||
                    (rd_acc && (dataram_rd_pld.dataram_rd_way == ICACHE_WAY_WIDTH'(w)));
    toy_mem_model_bit #(
      .ADDR_WIDTH (ICACHE_INDEX_WIDTH),
      .DATA_WIDTH (ICACHE_LINE_WIDTH)
    ) u_ram (
      .clk     (clk),
      .en      (ram_en),
      .wr_en   (ram_wr),
      .addr    (ram_addr),
      .wr_data (line_q),
      .rd_data (way_rd_data[w])
    );
  end

  assign push_data.txnid = pipe_txnid_q;
  assign push_data.data  = way_rd_data[pipe_way_q];

  icache_data_resp_fifo u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld_q),
    .push_data (push_data),
    .pop_vld   (resp_vld),
    .pop_rdy   (resp_rdy),
    .pop_data  (resp_pld),
    .cnt       (fifo_cnt)
  );

endmodule

// File: tb/tb_icache_data_array_ctrl.sv
// Directed bench for icache_data_array_ctrl with a response scoreboard fed from a line model.
`timescale 1ns/1ps
module tb_icache_data_array_ctrl;
  import toy_pack::*;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              dataram_rd_vld = 1'b0;
  logic                              dataram_rd_rdy;
  dataram_rd_pld_t                   dataram_rd_pld = '0;
  logic                              linefill_vld = 1'b0;
  logic                              linefill_rdy;
  linefill_beat_t                    linefill_pld = '0;
  logic                              linefill_done;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0] linefill_done_index;
  logic                              resp_vld;
  logic                              resp_rdy = 1'b1;
  dataram_resp_t                     resp_pld;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ICACHE_LINE_WIDTH-1:0] model_q [ICACHE_WAY_NUM][2**ICACHE_INDEX_WIDTH];
  dataram_resp_t exp_q [$];
  dataram_resp_t exp_e;
  dataram_resp_t prev_pld;
  bit            stall_prev = 1'b0;

  always #5 clk = ~clk;

  icache_data_array_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dataram_rd_vld      (dataram_rd_vld),
    .dataram_rd_rdy      (dataram_rd_rdy),
    .dataram_rd_pld      (dataram_rd_pld),
    .linefill_vld        (linefill_vld),
    .linefill_rdy        (linefill_rdy),
    .linefill_pld        (linefill_pld),
    .linefill_done       (linefill_done),
    .linefill_done_index (linefill_done_index),
    .resp_vld            (resp_vld),
    .resp_rdy            (resp_rdy),
    .resp_pld            (resp_pld)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [3:0] idx, input logic w, input logic [7:0] txn);
    dataram_rd_pld.dataram_rd_index = idx;
    dataram_rd_pld.dataram_rd_way   = w;
    dataram_rd_pld.dataram_rd_txnid = txn;
  endtask

  // Scoreboard: expectations captured at acceptance, checked at handshake; stall hold check.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("resp_hold", 256'({resp_vld, resp_pld}), 256'({1'b1, prev_pld}));
      end
      if (dataram_rd_vld && dataram_rd_rdy) begin
        exp_e.txnid = dataram_rd_pld.dataram_rd_txnid;
        exp_e.data  = model_q[dataram_rd_pld.dataram_rd_way][dataram_rd_pld.dataram_rd_index];
        exp_q.push_back(exp_e);
      end
      if (resp_vld && resp_rdy) begin
        if (exp_q.size() == 0) begin
          check("resp_extra", 256'(resp_vld), 256'(0));
        end else begin
          exp_e = exp_q.pop_front();
          check("resp_order", 256'(resp_pld), 256'(exp_e));
        end
      end
      stall_prev = resp_vld && !resp_rdy;
      prev_pld   = resp_pld;
    end
  end

  task automatic send_beat(input int k, input logic [3:0] idx, input logic w,
                           input logic [1:0] ent, input logic [127:0] line);
    linefill_vld             = 1'b1;
    linefill_pld.index       = (k == 0) ? idx : ~idx;
    linefill_pld.way         = (k == 0) ? w : ~w;
    linefill_pld.entry_index = (k == 0) ? ent : ~ent;
    linefill_pld.beat_data   = line[k*32 +: 32];
    @(negedge clk);
    check("lf_rdy_collect", 256'(linefill_rdy), 256'(1));
    step();
  endtask

  task automatic refill(input logic [3:0] idx, input logic w, input logic [1:0] ent,
                        input logic [127:0] line, input bit rd_in_write, input logic [7:0] txn);
    for (int k = 0; k < 4; k++) send_beat(k, idx, w, ent, line);
    linefill_vld = 1'b0;
    model_q[w][idx] = line;
    if (rd_in_write) begin
      dataram_rd_vld = 1'b1;
      set_rd(idx, w, txn);
    end
    @(negedge clk);
    check("lf_rdy_write", 256'(linefill_rdy), 256'(0));
    check("lf_done_early", 256'(linefill_done), 256'(0));
    if (rd_in_write) check("rd_rdy_write", 256'(dataram_rd_rdy), 256'(0));
    step();
    @(negedge clk);
    check("lf_done", 256'(linefill_done), 256'(1));
    check("lf_done_idx", 256'(linefill_done_index), 256'(ent));
    check("lf_rdy_after", 256'(linefill_rdy), 256'(1));
    if (rd_in_write) check("rd_rdy_after_write", 256'(dataram_rd_rdy), 256'(1));
    step();
    dataram_rd_vld = 1'b0;
    @(negedge clk);
    check("lf_done_pulse", 256'(linefill_done), 256'(0));
    step();
  endtask

  task automatic rd(input logic [3:0] idx, input logic w, input logic [7:0] txn);
    dataram_rd_vld = 1'b1;
    set_rd(idx, w, txn);
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      if (dataram_rd_rdy) break;
      if (c == 50) check("rd_timeout", 256'(dataram_rd_rdy), 256'(1));
      step();
    end
    step();
    dataram_rd_vld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] line_a, line_b, line_c, line_d, line_e;
    logic [3:0]   idx_l [4];
    logic         way_l [4];
    int           acc, txn, n, cyc, s;
    bit           got;
    line_a = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    line_b = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    line_c = {32'h0BADF00D, 32'hFEEDFACE, 32'hCAFEBABE, 32'hDEADBEEF};
    line_d = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    line_e = {4{32'h5A5A5A5A}};
    idx_l  = '{4'd5, 4'd0, 4'd2, 4'd7};
    way_l  = '{1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_lf_rdy", 256'(linefill_rdy), 256'(1));
    check("rst_done", 256'(linefill_done), 256'(0));
    check("rst_resp_vld", 256'(resp_vld), 256'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rd_rdy", 256'(dataram_rd_rdy), 256'(1));
    check("rst_resp_vld_rel", 256'(resp_vld), 256'(0));
    step();

    // Refill idx5 way1 entry3, then read it back with latency T+2
    refill(4'd5, 1'b1, 2'd3, line_a, 1'b0, 8'd0);
    dataram_rd_vld = 1'b1;
    set_rd(4'd5, 1'b1, 8'd7);
    @(negedge clk);
    check("rd7_rdy", 256'(dataram_rd_rdy), 256'(1));
    step();
    dataram_rd_vld = 1'b0;
    @(negedge clk);
    check("rd7_lat_t1", 256'(resp_vld), 256'(0));
    step();
    @(negedge clk);
    check("rd7_vld_t2", 256'(resp_vld), 256'(1));
    check("rd7_pld", 256'(resp_pld), 256'({8'd7, line_a}));
    step();

    refill(4'd0, 1'b1, 2'd1, line_b, 1'b0, 8'd0);

    // Back-to-back reads, consumer always ready
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        dataram_rd_vld = 1'b1;
        if (c % 2 == 1) set_rd(4'd0, 1'b1, 8'(c + 1));
        else set_rd(4'd5, 1'b1, 8'(c + 1));
      end else begin
        dataram_rd_vld = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check("b2b_rd_rdy", 256'(dataram_rd_rdy), 256'(1));
      if (c >= 2) begin
        check("b2b_resp_vld", 256'(resp_vld), 256'(1));
        check("b2b_txn", 256'(resp_pld.txnid), 256'(c - 1));
      end else begin
        check("b2b_lat", 256'(resp_vld), 256'(0));
      end
      step();
    end

    // Consumer stalled: only two reads fit
    resp_rdy = 1'b0;
    acc = 0;
    txn = 10;
    dataram_rd_vld = 1'b1;
    set_rd(4'd5, 1'b1, 8'(txn));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = dataram_rd_vld && dataram_rd_rdy;
      step();
      if (got) begin
        acc++;
        txn++;
        set_rd((txn % 2 == 1) ? 4'd0 : 4'd5, 1'b1, 8'(txn));
      end
    end
    check("stall_accepts", 256'(acc), 256'(2));
    @(negedge clk);
    check("stall_rd_rdy", 256'(dataram_rd_rdy), 256'(0));
    step();
    resp_rdy = 1'b1;
    @(negedge clk);
    check("pop_resp_vld", 256'(resp_vld), 256'(1));
    check("pop_txn0", 256'(resp_pld.txnid), 256'(10));
    check("pop_third_rdy", 256'(dataram_rd_rdy), 256'(1));
    step();
    dataram_rd_vld = 1'b0;
    @(negedge clk);
    check("pop_txn1", 256'(resp_pld.txnid), 256'(11));
    step();
    repeat (4) step();
    check("stall_drain", 256'(exp_q.size()), 256'(0));

    // Read presented during the WRITE cycle returns the freshly written line
    refill(4'd2, 1'b0, 2'd2, line_c, 1'b1, 8'd20);
    repeat (4) step();
    check("wr_rd_drain", 256'(exp_q.size()), 256'(0));

    // Reset after three beats: partial line to idx5 way1 is discarded
    for (int k = 0; k < 3; k++) send_beat(k, 4'd5, 1'b1, 2'd0, line_e);
    linefill_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_lf_rdy", 256'(linefill_rdy), 256'(1));
    check("mid_rst_done", 256'(linefill_done), 256'(0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", 256'(linefill_done), 256'(0));
      step();
    end
    refill(4'd7, 1'b0, 2'd2, line_d, 1'b0, 8'd0);
    rd(4'd5, 1'b1, 8'd30);
    repeat (4) step();
    check("rst_rd_drain", 256'(exp_q.size()), 256'(0));

    // Random consumer stalls over 200 reads
    n = 0;
    cyc = 0;
    dataram_rd_vld = 1'b0;
    while (n < 200 && cyc < 5000) begin
      resp_rdy = 1'($urandom_range(0, 1));
      if (!dataram_rd_vld && $urandom_range(0, 3) != 0) begin
        s = int'($urandom_range(0, 3));
        set_rd(idx_l[s], way_l[s], 8'(n + 100));
        dataram_rd_vld = 1'b1;
      end
      @(negedge clk);
      got = dataram_rd_vld && dataram_rd_rdy;
      step();
      cyc++;
      if (got) begin
        n++;
        dataram_rd_vld = 1'b0;
      end
    end
    dataram_rd_vld = 1'b0;
    check("rand_count", 256'(n), 256'(200));
    resp_rdy = 1'b1;
    repeat (6) step();
    check("rand_drain", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_data_array_ctrl.md
ICACHE_DATA_ARRAY_CTRL -- requirements
Module: icache_data_array_ctrl

Interface
REQ-001 clk  input  1  clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 dataram_rd_vld  input  1  read request from tag control (tag hit, pre-check passed).
REQ-004 dataram_rd_rdy  output  1  read request accepted when vld&&rdy.
REQ-005 dataram_rd_pld  input  dataram_rd_pld_t  {dataram_rd_index, dataram_rd_way, dataram_rd_txnid}.
REQ-006 linefill_vld  input  1  downstream refill beat valid.
REQ-007 linefill_rdy  output  1  beat accepted when vld&&rdy.
REQ-008 linefill_pld  input  linefill_beat_t  {index, way, entry_index (MSHR_ENTRY_INDEX_WIDTH), beat_data (ICACHE_BEAT_WIDTH)}.
REQ-009 linefill_done  output  1  one-cycle pulse: full line written to data RAM.
REQ-010 linefill_done_index  output  MSHR_ENTRY_INDEX_WIDTH  MSHR entry whose line was written; valid with linefill_done.
REQ-011 resp_vld  output  1  read response valid.
REQ-012 resp_rdy  input  1  response consumer ready.
REQ-013 resp_pld  output  dataram_resp_t  {txnid, line data ICACHE_LINE_WIDTH}.

Function
REQ-014 Storage: one RAM per way, ICACHE_INDEX_WIDTH address, ICACHE_LINE_WIDTH data, 1-cycle registered read.
REQ-015 Refill FSM states IDLE, COLLECT, WRITE; IDLE->COLLECT on first accepted beat; COLLECT->WRITE on accepted beat LINEFILL_BEAT_NUM-1; WRITE->IDLE unconditionally after one cycle.
REQ-016 Beat counter (clog2(LINEFILL_BEAT_NUM) bits) starts at 0, increments per accepted beat, wraps to 0 on last beat; beat k stored at line bits [k*ICACHE_BEAT_WIDTH +: ICACHE_BEAT_WIDTH].
REQ-017 index, way, entry_index latched from beat 0; ignored on later beats.
REQ-018 linefill_rdy = 1 in IDLE and COLLECT, 0 in WRITE.
REQ-019 WRITE cycle: write assembled line to RAM[way][index]; no read issued that cycle.
REQ-020 linefill_done pulses for exactly one cycle, the cycle after WRITE, with latched entry_index.
REQ-021 dataram_rd_rdy = (state!=WRITE) && (fifo_cnt + pipe_vld - (resp_vld&&resp_rdy) < 2).
REQ-022 Accepted read in cycle T: RAM read T, pipe register holds {txnid, way} T+1, data pushed to 2-entry response FIFO end of T+1, resp_vld earliest T+2.
REQ-023 Responses returned in acceptance order; no drop or duplication under any resp_rdy pattern.
REQ-024 resp_pld held stable while resp_vld && !resp_rdy.
REQ-025 FIFO push and pop in same cycle at count 1 or 2: count unchanged, order preserved.
REQ-026 Read of index/way being refilled not checked here (tag-side bitmap guarantees exclusion); read issued after WRITE returns new line.
REQ-027 Sustained throughput with resp_rdy=1 and no refill: one read accepted per cycle.

Reset
REQ-028 On rst_n low: state=IDLE, beat counter 0, pipe_vld 0, FIFO empty; outputs dataram_rd_rdy 1 (after release), linefill_rdy 1, linefill_done 0, resp_vld 0.
REQ-029 Reset mid-refill discards partial line; RAM contents not cleared by reset.
REQ-030 Line buffer, pipe payload, FIFO data have no reset.

Structure
REQ-031 toy_pack gains ICACHE_LINE_WIDTH, LINEFILL_BEAT_NUM, ICACHE_BEAT_WIDTH, linefill_beat_t, dataram_resp_t; dataram_rd_pld_t reused unchanged.
REQ-032 RAMs instantiated from toy_mem_model_bit, one per way.
REQ-033 One sub-module: icache_data_resp_fifo (2-entry, valid/ready, push/pop/count).

Verification
REQ-034 Refill LINEFILL_BEAT_NUM=4, index 5, way 1, entry 3, beats A,B,C,D -> linefill_rdy 0 one cycle, linefill_done pulse next cycle with index 3; later read idx5 way1 txnid 7 -> resp {7, D:C:B:A} at T+2.
REQ-035 Back-to-back reads txnid 1,2,3,4, resp_rdy=1 -> rd_rdy never drops, responses 1,2,3,4 on consecutive cycles from T+2.
REQ-036 resp_rdy=0, reads issued continuously -> exactly 2 accepted, rd_rdy 0 thereafter; resp_rdy 1 -> both returned in order, third accepted same cycle first pops.
REQ-037 Read vld during WRITE cycle -> rd_rdy 0 that cycle, accepted next cycle, data correct.
REQ-038 rst_n asserted after beat 2 of 4 -> no linefill_done, new 4-beat refill after release completes normally.
REQ-039 Random resp_rdy stall pattern, 200 reads -> scoreboard order and data match, resp_pld stable while stalled.
